rec_unit_mq: RTL

Parametrised, multi-order successor to the receive/transfer unit. It queues user send orders (up to ORDER_DEPTH pending) and, per order, pulls exactly ORDER_IMGS processed samples from the result buffer. Samples go out on the AXI-side port with a valid/ready handshake, so the PS can apply backpressure. It sits between the processed-data buffer and the AXI port to the PS, and is enabled by the decoder.

---
 rtl/rec_unit_mq.sv | 89 ++++++++
 1 files changed

// File: rtl/rec_unit_mq.sv
// rec_unit_mq: queues send orders and streams ORDER_IMGS buffer samples per order to the AXI side with valid/ready backpressure
module rec_unit_mq #(
  parameter int FIFO_DATA   = 25,
  parameter int ORDER_IMGS  = 50,
  parameter int ORDER_DEPTH = 4,
  parameter int ADDR_W      = 7,
  parameter int CNT_W       = $clog2(ORDER_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rec_en,
  input  logic                 order_come,
  input  logic [FIFO_DATA-1:0] buf_in,
  input  logic                 valid,
  output logic                 send_enB,
  output logic [FIFO_DATA-1:0] AXI_OUT,
  output logic                 axi_valid,
  input  logic                 axi_ready,
  output logic [ADDR_W-1:0]    ramadd,
  output logic [CNT_W-1:0]     order_cnt,
  output logic                 order_full,
  output logic                 no_order,
  output logic                 sending,
  output logic                 frame_done,
  output logic                 order_drop
);
  localparam int IW = $clog2(ORDER_IMGS + 1);
  localparam logic [IW-1:0] IMGS = IW'(ORDER_IMGS);
  localparam logic [IW-1:0] LAST = IW'(ORDER_IMGS - 1);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(ORDER_DEPTH);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] issued_q, issued_d, accepted_q, accepted_d;
  logic [CNT_W-1:0] order_cnt_q, order_cnt_d;
  logic [FIFO_DATA-1:0] axi_out_q, axi_out_d;
  logic [ADDR_W-1:0] ramadd_q, ramadd_d;
  logic axi_valid_q, axi_valid_d, frame_done_q, frame_done_d, order_drop_q, order_drop_d;
  logic cap, acc, last, inc, start;
  assign sending    = state_q == XFER;
  assign order_cnt  = order_cnt_q;
  assign order_full = order_cnt_q == DEPTH;
  assign no_order   = order_cnt_q == '0;
  assign AXI_OUT    = axi_out_q;
  assign axi_valid  = axi_valid_q;
  assign ramadd     = ramadd_q;
  assign frame_done = frame_done_q;
  assign order_drop = order_drop_q;
  // A new sample may be pulled only when the output register is empty or draining this cycle
  always_comb begin
    send_enB     = sending & rec_en & (issued_q < IMGS) & (~axi_valid_q | axi_ready);
    cap          = send_enB & valid;
    acc          = axi_valid_q & axi_ready;
    last         = sending & acc & (accepted_q == LAST);
    inc          = order_come & ~order_full;
    start        = (state_q == IDLE) & ~no_order & rec_en;
    state_d      = start ? XFER : last ? IDLE : state_q;
    issued_d     = start ? '0 : cap ? issued_q + IW'(1) : issued_q;
    accepted_d   = start ? '0 : acc ? accepted_q + IW'(1) : accepted_q;
    order_cnt_d  = order_cnt_q + CNT_W'(inc) - CNT_W'(last);
    axi_out_d    = cap ? buf_in : axi_out_q;
    ramadd_d     = cap ? ADDR_W'(issued_q) : ramadd_q;
    axi_valid_d  = cap | (axi_valid_q & ~axi_ready);
    frame_done_d = last;
    order_drop_d = order_come & order_full;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      issued_q     <= '0;
      accepted_q   <= '0;
      order_cnt_q  <= '0;
      axi_out_q    <= '0;
      ramadd_q     <= '0;
      axi_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      order_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      accepted_q   <= accepted_d;
      order_cnt_q  <= order_cnt_d;
      axi_out_q    <= axi_out_d;
      ramadd_q     <= ramadd_d;
      axi_valid_q  <= axi_valid_d;
      frame_done_q <= frame_done_d;
      order_drop_q <= order_drop_d;
    end
  end
endmodule
